// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and EX/MEM forwarding
// selects, driven by a three-entry tracker of in-flight destination registers.
module pipe_hazard_ctrl #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int STALL_CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dec_valid,
    input  logic [REGFILE_ADDR_WIDTH-1:0] dec_R1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] dec_R2_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] dec_WR_addr,
    input  logic                          dec_wr_en,
    input  logic                          dec_is_load,
    input  logic                          ex_busy,
    input  logic                          branch_taken,
    output logic                          en_fd,
    output logic                          en_de,
    output logic                          flush_fd,
    output logic                          flush_de,
    output logic [1:0]                    fwd_R1_sel,
    output logic [1:0]                    fwd_R2_sel,
    output logic [STALL_CNT_WIDTH-1:0]    stall_count
);

    typedef struct packed {
        logic                          valid;
        logic [REGFILE_ADDR_WIDTH-1:0] wr_addr;
        logic                          is_load;
    } entry_t;

    localparam entry_t BUBBLE = '0;

    entry_t     ex_q, mem_q, wb_q;
    logic [1:0] flush_cnt;
    logic       flush_active;
    logic       load_use;
    logic       ex_hit_r1, ex_hit_r2, mem_hit_r1, mem_hit_r2;

    // Register 0 is hardwired, so it never produces a hazard.
    function automatic logic hits(entry_t e, logic [REGFILE_ADDR_WIDTH-1:0] addr);
        return e.valid && (e.wr_addr != '0) && (e.wr_addr == addr);
    endfunction

    function automatic logic [1:0] fwd_sel(logic ex_hit, logic mem_hit);
        return ex_hit ? 2'd1 : (mem_hit ? 2'd2 : 2'd0);
    endfunction

    always_comb begin
        flush_active = (flush_cnt != 2'd0);
        ex_hit_r1    = hits(ex_q, dec_R1_addr);
        ex_hit_r2    = hits(ex_q, dec_R2_addr);
        mem_hit_r1   = hits(mem_q, dec_R1_addr);
        mem_hit_r2   = hits(mem_q, dec_R2_addr);
        load_use     = dec_valid && !flush_active && ex_q.is_load && (ex_hit_r1 || ex_hit_r2);
        en_fd        = !(load_use || ex_busy);
        en_de        = !ex_busy;
        flush_fd     = flush_active;
        flush_de     = flush_active || (load_use && !ex_busy);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            flush_cnt   <= 2'd0;
            fwd_R1_sel  <= 2'd0;
            fwd_R2_sel  <= 2'd0;
            stall_count <= '0;
        end else begin
            // A branch seen while execute is stalled is re-presented, so ignore it here.
            if (branch_taken && !ex_busy)
                flush_cnt <= 2'd2;
            else if (flush_active)
                flush_cnt <= flush_cnt - 2'd1;

            if (ex_busy) begin
                mem_q <= BUBBLE;
                wb_q  <= mem_q;
            end else begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                if (en_fd && !flush_active)
                    ex_q <= {dec_valid && dec_wr_en, dec_WR_addr, dec_is_load};
                else
                    ex_q <= BUBBLE;
            end

            if (en_de) begin
                if (flush_de) begin
                    fwd_R1_sel <= 2'd0;
                    fwd_R2_sel <= 2'd0;
                end else begin
                    fwd_R1_sel <= fwd_sel(ex_hit_r1, mem_hit_r1);
                    fwd_R2_sel <= fwd_sel(ex_hit_r2, mem_hit_r2);
                end
            end

            if (load_use && !ex_busy && (stall_count != '1))
                stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int AW  = 5;
    localparam int SW  = 6;
    localparam int SAT = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          dec_valid;
    logic [AW-1:0] dec_R1_addr, dec_R2_addr, dec_WR_addr;
    logic          dec_wr_en, dec_is_load, ex_busy, branch_taken;
    logic          en_fd, en_de, flush_fd, flush_de;
    logic [1:0]    fwd_R1_sel, fwd_R2_sel;
    logic [SW-1:0] stall_count;

    pipe_hazard_ctrl #(.REGFILE_ADDR_WIDTH(AW), .STALL_CNT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_R1_addr(dec_R1_addr), .dec_R2_addr(dec_R2_addr),
        .dec_WR_addr(dec_WR_addr), .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load),
        .ex_busy(ex_busy), .branch_taken(branch_taken),
        .en_fd(en_fd), .en_de(en_de), .flush_fd(flush_fd), .flush_de(flush_de),
        .fwd_R1_sel(fwd_R1_sel), .fwd_R2_sel(fwd_R2_sel), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: in-flight writers by stage index (0 = EX, 1 = MEM, 2 = WB),
    // flush expressed as "within two cycles of the last accepted branch".
    int pv[3], pa[3], pl[3];
    int cyc     = 0;
    int last_br = -100;
    int m_stall = 0;
    int m_f1    = 0;
    int m_f2    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_flushing();
        return (cyc - last_br) >= 1 && (cyc - last_br) <= 2;
    endfunction

    function automatic bit m_hit(input int s, input int r);
        return pv[s] != 0 && pa[s] != 0 && pa[s] == r;
    endfunction

    function automatic bit m_load_use();
        return dec_valid && !m_flushing() && pl[0] != 0 &&
               (m_hit(0, int'(dec_R1_addr)) || m_hit(0, int'(dec_R2_addr)));
    endfunction

    function automatic int m_sel(input int r);
        if (m_hit(0, r)) return 1;
        if (m_hit(1, r)) return 2;
        return 0;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < 3; s++) begin
            pv[s] = 0; pa[s] = 0; pl[s] = 0;
        end
        last_br = -100;
        m_stall = 0;
        m_f1    = 0;
        m_f2    = 0;
    endtask

    task automatic model_step();
        bit lu, fl;
        if (!reset) begin
            m_clear();
            cyc++;
            return;
        end
        lu = m_load_use();
        fl = m_flushing();
        if (!ex_busy) begin
            if (lu && m_stall < SAT) m_stall++;
            if (fl || lu) begin
                m_f1 = 0; m_f2 = 0;
            end else begin
                m_f1 = m_sel(int'(dec_R1_addr));
                m_f2 = m_sel(int'(dec_R2_addr));
            end
            pv[2] = pv[1]; pa[2] = pa[1]; pl[2] = pl[1];
            pv[1] = pv[0]; pa[1] = pa[0]; pl[1] = pl[0];
            if (!lu && !fl) begin
                pv[0] = int'(dec_valid && dec_wr_en);
                pa[0] = int'(dec_WR_addr);
                pl[0] = int'(dec_is_load);
            end else begin
                pv[0] = 0; pa[0] = 0; pl[0] = 0;
            end
            if (branch_taken) last_br = cyc;
        end else begin
            pv[2] = pv[1]; pa[2] = pa[1]; pl[2] = pl[1];
            pv[1] = 0;     pa[1] = 0;     pl[1] = 0;
        end
        cyc++;
    endtask

    task automatic compare_all();
        bit lu, fl;
        lu = m_load_use();
        fl = m_flushing();
        chk("en_fd",       en_fd,       !(lu || ex_busy));
        chk("en_de",       en_de,       !ex_busy);
        chk("flush_fd",    flush_fd,    fl);
        chk("flush_de",    flush_de,    fl || (lu && !ex_busy));
        chk("fwd_R1_sel",  fwd_R1_sel,  m_f1);
        chk("fwd_R2_sel",  fwd_R2_sel,  m_f2);
        chk("stall_count", stall_count, m_stall);
    endtask

    task automatic drive(input bit v, input int r1, input int r2, input int wr,
                         input bit we, input bit ld, input bit busy, input bit br);
        dec_valid    = v;
        dec_R1_addr  = AW'(r1);
        dec_R2_addr  = AW'(r2);
        dec_WR_addr  = AW'(wr);
        dec_wr_en    = we;
        dec_is_load  = ld;
        ex_busy      = busy;
        branch_taken = br;
    endtask

    task automatic set(input bit v, input int r1, input int r2, input int wr,
                       input bit we, input bit ld, input bit busy, input bit br);
        @(posedge clk);
        model_step();
        @(negedge clk);
        drive(v, r1, r2, wr, we, ld, busy, br);
        #1;
        compare_all();
    endtask

    task automatic idle();
        set(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted mid-cycle: outputs must clear before the next rising edge.
    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        m_clear();
        chk("rst en_fd",    en_fd,       1);
        chk("rst en_de",    en_de,       1);
        chk("rst flush_fd", flush_fd,    0);
        chk("rst flush_de", flush_de,    0);
        chk("rst fwd_R1",   fwd_R1_sel,  0);
        chk("rst fwd_R2",   fwd_R2_sel,  0);
        chk("rst stall",    stall_count, 0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        m_clear();
        #2;
        reset = 1'b0;
        #1;
        chk("init stall", stall_count, 0);
        chk("init fwd_R1", fwd_R1_sel, 0);
        chk("init en_fd", en_fd, 1);
        chk("init flush_de", flush_de, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare_all();

        // Load r5 then add r7 <- r5, r2: one stall, then forward from WB.
        set(1, 0, 0, 5, 1, 1, 0, 0);
        chk("lu load en_fd", en_fd, 1);
        set(1, 5, 2, 7, 1, 0, 0, 0);
        chk("lu en_fd", en_fd, 0);
        chk("lu flush_de", flush_de, 1);
        set(1, 5, 2, 7, 1, 0, 0, 0);
        chk("lu stall_count", stall_count, 1);
        chk("lu reissue en_fd", en_fd, 1);
        idle();
        chk("lu fwd_R1_sel", fwd_R1_sel, 2);

        // ALU producer r3 then reader at distances 1, 2, 3.
        do_reset();
        set(1, 0, 0, 3, 1, 0, 0, 0);
        set(1, 0, 3, 4, 1, 0, 0, 0);
        chk("alu0 en_fd", en_fd, 1);
        idle();
        chk("alu0 fwd_R2_sel", fwd_R2_sel, 1);
        set(1, 0, 0, 3, 1, 0, 0, 0);
        set(1, 0, 0, 0, 0, 0, 0, 0);
        set(1, 0, 3, 4, 1, 0, 0, 0);
        idle();
        chk("alu1 fwd_R2_sel", fwd_R2_sel, 2);
        set(1, 0, 0, 3, 1, 0, 0, 0);
        set(1, 0, 0, 0, 0, 0, 0, 0);
        set(1, 0, 0, 0, 0, 0, 0, 0);
        set(1, 0, 3, 4, 1, 0, 0, 0);
        idle();
        chk("alu2 fwd_R2_sel", fwd_R2_sel, 0);

        // Load to r0 never stalls or forwards.
        set(1, 0, 0, 0, 1, 1, 0, 0);
        set(1, 0, 0, 6, 1, 0, 0, 0);
        chk("r0 en_fd", en_fd, 1);
        idle();
        chk("r0 fwd_R1_sel", fwd_R1_sel, 0);
        chk("r0 fwd_R2_sel", fwd_R2_sel, 0);

        // Single branch pulse, then back-to-back pulses.
        set(0, 0, 0, 0, 0, 0, 0, 1);
        chk("br N flush_fd", flush_fd, 0);
        idle();
        chk("br N+1 flush_fd", flush_fd, 1);
        chk("br N+1 flush_de", flush_de, 1);
        idle();
        chk("br N+2 flush_fd", flush_fd, 1);
        idle();
        chk("br N+3 flush_fd", flush_fd, 0);
        set(0, 0, 0, 0, 0, 0, 0, 1);
        set(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        chk("br2 N+3 flush_fd", flush_fd, 1);
        idle();
        chk("br2 N+4 flush_fd", flush_fd, 0);

        // ex_busy for 3 cycles with a load-use pending.
        do_reset();
        set(1, 0, 0, 6, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            set(1, 6, 0, 8, 1, 0, 1, 0);
            chk("busy en_de", en_de, 0);
            chk("busy en_fd", en_fd, 0);
            chk("busy stall", stall_count, 0);
        end
        set(1, 6, 0, 8, 1, 0, 0, 0);
        chk("busy-after flush_de", flush_de, 1);
        idle();
        chk("busy-after stall", stall_count, 1);

        // Both sources on the same loaded register count one stall.
        do_reset();
        set(1, 0, 0, 5, 1, 1, 0, 0);
        set(1, 5, 5, 9, 1, 0, 0, 0);
        idle();
        chk("dual src stall", stall_count, 1);

        // Saturation, then asynchronous reset in the middle of a flush.
        for (int k = 0; k < SAT + 6; k++) begin
            set(1, 0, 0, 5, 1, 1, 0, 0);
            set(1, 5, 0, 6, 1, 0, 0, 0);
        end
        idle();
        chk("sat stall", stall_count, SAT);
        set(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("pre-rst flush_fd", flush_fd, 1);
        do_reset();
        chk("post-rst flush_fd", flush_fd, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                set($urandom_range(0, 9) < 8,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 2, $urandom_range(0, 11) == 0);
        end

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
